// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter: colour type, screen
// geometry and the blit sequencing states.
package sprite_pkg;

  typedef logic [23:0] rgb_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE,
    ADVANCE,
    DONE
  } blit_state_t;

endpackage

// File: rtl/sprite_blit_cursor.sv
// Raster cursor over the sprite texels: col runs fastest, row wraps after
// the last column. o_last flags the final texel of the sprite.
module sprite_blit_cursor #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == CW'(SPRITE_W - 1));
  assign w_row_end = (r_row == RW'(SPRITE_H - 1));

  // Step the cursor one texel in raster order, or rewind it to texel 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_row_end && w_col_end;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks every texel of a sprite, reads its colour from a
// 1-cycle-latency ROM and writes on-screen texels into a 640x480 frame
// buffer with ready/valid backpressure.
// Optional feature macro: SPRITE_BLIT_TRANSPARENCY_EN -- when defined,
// texels equal to TRANSPARENT_COLOR are skipped instead of written.
module sprite_blitter #(
  parameter int                SPRITE_W          = 32,
  parameter int                SPRITE_H          = 32,
  parameter int                SCREEN_W          = sprite_pkg::SCREEN_W,
  parameter int                SCREEN_H          = sprite_pkg::SCREEN_H,
  parameter logic [18:0]       ROM_BASE          = 19'd0,
  parameter sprite_pkg::rgb_t  TRANSPARENT_COLOR = 24'hFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic        busy,
  output logic        done,
  output logic [18:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic [10:0] written_count
);

  import sprite_pkg::*;

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  blit_state_t  r_state;
  logic [9:0]   r_sx;
  logic [9:0]   r_sy;
  logic         r_busy;
  logic         r_done;
  logic [18:0]  r_rom_addr;
  logic [18:0]  r_fb_addr;
  rgb_t         r_fb_data;
  logic         r_fb_we;
  logic [10:0]  r_count;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_last;
  logic          w_clear;
  logic          w_advance;
  logic [10:0]   w_px;
  logic [10:0]   w_py;
  logic          w_offscreen;
  logic          w_is_key;
  logic          w_skip;
  logic [18:0]   w_fb_addr;

  assign w_clear   = (r_state == IDLE) && start;
  assign w_advance = (r_state == ADVANCE);

  sprite_blit_cursor #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_cursor (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );

  // Screen position of the current texel, kept at 11 bits so a sprite
  // hanging past the right/bottom edge compares correctly instead of wrapping.
  assign w_px        = {1'b0, r_sx} + 11'(w_col);
  assign w_py        = {1'b0, r_sy} + 11'(w_row);
  assign w_offscreen = (w_px >= 11'(SCREEN_W)) || (w_py >= 11'(SCREEN_H));
  assign w_is_key    = (rom_data == TRANSPARENT_COLOR);
  assign w_skip      = w_offscreen || (TRANSP_EN && w_is_key);
  assign w_fb_addr   = 19'(w_py) * 19'(SCREEN_W) + 19'(w_px);

  // Blit sequencer: fetch, capture, optional write, advance, per texel.
  // The ROM address is a linear counter: in raster order it always equals
  // ROM_BASE + row*SPRITE_W + col, and it is ready before FETCH begins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_sx       <= '0;
      r_sy       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rom_addr <= '0;
      r_fb_addr  <= '0;
      r_fb_data  <= '0;
      r_fb_we    <= 1'b0;
      r_count    <= '0;
    end else begin
      // NOTE: done is defaulted low at the top of the block so it is a
      // single-cycle pulse; the later assignment in ADVANCE wins when taken.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sx       <= sprite_x;
            r_sy       <= sprite_y;
            r_count    <= '0;
            r_rom_addr <= ROM_BASE;
            r_busy     <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_fb_data <= rom_data;
          if (w_skip) begin
            r_state <= ADVANCE;
          end else begin
            r_fb_addr <= w_fb_addr;
            r_fb_we   <= 1'b1;
            r_state   <= WRITE;
          end
        end
        WRITE: begin
          if (fb_ready) begin
            r_fb_we <= 1'b0;
            r_count <= r_count + 11'd1;
            r_state <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_rom_addr <= r_rom_addr + 19'd1;
            r_state    <= FETCH;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign rom_addr      = r_rom_addr;
  assign fb_addr       = r_fb_addr;
  assign fb_data       = r_fb_data;
  assign fb_we         = r_fb_we;
  assign written_count = r_count;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a registered ROM model, a
// scoreboard of expected frame-buffer writes built from the sprite origin
// and ROM contents, and directed scenarios for reset, backpressure,
// clipping, transparency and mid-blit reset.
module tb_sprite_blitter;

  localparam int MAX_CYC = 20000;

  logic        Clk;
  logic        Reset_n;
  logic        start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        busy;
  logic        done;
  logic [18:0] rom_addr;
  logic [23:0] rom_data;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic [10:0] written_count;

  sprite_blitter dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .fb_ready      (fb_ready),
    .written_count (written_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          rom_mode   = 0;
  bit          rand_ready = 1'b0;
  logic [63:0] sb_q[$];
  int          exp_writes;
  int          wr_accepts;
  logic [18:0] first_addr;
  logic [18:0] last_addr;
  int          hits_32105;
  int          done_cnt   = 0;
  int          done_base;
  logic [18:0] last_rom   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] rom_fn(input int mode, input int a);
    case (mode)
      1:       return (a == 5) ? 24'hFFFFFF : 24'h000000;
      2:       return {5'h15, 19'(a)};
      default: return 24'h000000;
    endcase
  endfunction

  // Registered ROM: data for the address presented this cycle appears next cycle.
  always @(posedge Clk) rom_data <= rom_fn(rom_mode, int'(rom_addr));

  // Random backpressure source, active only when enabled.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: accepted writes against the scoreboard, done pulses, ROM order.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (fb_we && fb_ready) begin
        wr_accepts++;
        if (wr_accepts == 1) first_addr = fb_addr;
        last_addr = fb_addr;
        if (fb_addr == 19'd32105) hits_32105++;
        check("fb_addr_in_screen", 64'(fb_addr < 19'd307200), 64'd1);
        check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("fb_write", {21'b0, fb_addr, fb_data}, sb_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("busy_low_in_done", 64'(busy), 64'd0);
      end
      if (busy && rom_addr != last_rom) begin
        check("rom_seq", 64'(rom_addr), 64'(last_rom + 19'd1));
        last_rom = rom_addr;
      end
    end
  end

  task automatic push_expected(input int sx, input int sy, input int mode);
    logic [23:0] col;
    bit          skip;
    exp_writes = 0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        col  = rom_fn(mode, r * 32 + c);
        skip = (sx + c >= 640) || (sy + r >= 480);
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
        if (col == 24'hFFFFFF) skip = 1'b1;
`endif
        if (!skip) begin
          sb_q.push_back({21'b0, 19'((sy + r) * 640 + sx + c), col});
          exp_writes++;
        end
      end
    end
  endtask

  task automatic do_start(input int sx, input int sy, input int mode);
    push_expected(sx, sy, mode);
    rom_mode   = mode;
    wr_accepts = 0;
    hits_32105 = 0;
    done_base  = done_cnt;
    start      = 1'b1;
    sprite_x   = 10'(sx);
    sprite_y   = 10'(sy);
    @(posedge Clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("rom_addr_first", 64'(rom_addr), 64'd0);
    check("count_cleared", 64'(written_count), 64'd0);
    last_rom = '0;
  endtask

  task automatic wait_done(input int poke_at);
    int cyc = 0;
    while (done_cnt == done_base && cyc < MAX_CYC) begin
      if (cyc == poke_at) begin
        start    = 1'b1;
        sprite_x = 10'd0;
        sprite_y = 10'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge Clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    check("one_done_pulse", 64'(done_cnt - done_base), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("written_count", 64'(written_count), 64'(exp_writes));
    check("accepted_writes", 64'(wr_accepts), 64'(exp_writes));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("rom_last_addr", 64'(last_rom), 64'd1023);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    Reset_n  = 1'b1;
    start    = 1'b0;
    sprite_x = '0;
    sprite_y = '0;
    fb_ready = 1'b1;

    // Reset asserted mid-cycle clears outputs without waiting for a clock.
    #3 Reset_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_count", 64'(written_count), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Basic blit at (100,50), all-black ROM, with an ignored start mid-blit.
    do_start(100, 50, 0);
    wait_done(100);
    check("basic_first_addr", 64'(first_addr), 64'd32100);
    check("basic_last_addr", 64'(last_addr), 64'd51971);
    check("basic_count", 64'(written_count), 64'd1024);

    // Transparency: texel 5 is the key colour.
    do_start(100, 50, 1);
    wait_done(-1);
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    check("transp_count", 64'(written_count), 64'd1023);
    check("transp_hits_32105", 64'(hits_32105), 64'd0);
`else
    check("transp_count", 64'(written_count), 64'd1024);
    check("transp_hits_32105", 64'(hits_32105), 64'd1);
`endif

    // Backpressure: hold fb_ready low for 7 cycles on the first write.
    fb_ready = 1'b0;
    do_start(100, 50, 2);
    cyc = 0;
    while (!fb_we && cyc < 20) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    check("bp_we_seen", 64'(fb_we), 64'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      #1;
      check("bp_we_stable", 64'(fb_we), 64'd1);
      check("bp_addr_stable", 64'(fb_addr), 64'd32100);
      check("bp_data_stable", 64'(fb_data), 64'hA80000);
      @(posedge Clk);
      #1;
    end
    check("bp_none_accepted", 64'(wr_accepts), 64'd0);
    fb_ready = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_one_accepted", 64'(wr_accepts), 64'd1);
    check("bp_we_dropped", 64'(fb_we), 64'd0);
    @(negedge Clk);
    #1;
    check("bp_still_one", 64'(wr_accepts), 64'd1);
    wait_done(-1);

    // Clipping at (620,470) with random backpressure.
    rand_ready = 1'b1;
    do_start(620, 470, 2);
    wait_done(-1);
    rand_ready = 1'b0;
    @(posedge Clk);
    #1;
    fb_ready = 1'b1;
    check("clip_count", 64'(written_count), 64'd200);

    // Reset in the middle of a blit, with a write pending.
    do_start(100, 50, 2);
    cyc = 0;
    while (wr_accepts < 10 && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    fb_ready = 1'b0;
    check("pre_reset_count", 64'(written_count), 64'd10);
    cyc = 0;
    while (!fb_we && cyc < 20) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    check("pre_reset_we", 64'(fb_we), 64'd1);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_fb_we", 64'(fb_we), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_count", 64'(written_count), 64'd0);
    sb_q.delete();
    @(posedge Clk);
    #1;
    Reset_n  = 1'b1;
    fb_ready = 1'b1;
    @(posedge Clk);
    #1;
    do_start(0, 0, 2);
    wait_done(-1);
    check("restart_first_addr", 64'(first_addr), 64'd0);
    check("restart_count", 64'(written_count), 64'd1024);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Read-side initiator for the 1-bit-indexed sprite frame ROMs (palette-expanded 24-bit output, registered, 1-cycle read latency).
- On `start`, walks every sprite texel, fetches its colour from the ROM, and writes it into the 640x480 frame buffer at a screen position.
- Skips pixels that fall off-screen; handles write backpressure.
- Sits between game logic (digit/tank sprites) and the frame-buffer write port.

Parameters:
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels.
- SCREEN_W, 640, frame-buffer width.
- SCREEN_H, 480, frame-buffer height.
- ROM_BASE, 0, first ROM address of the sprite.
- TRANSPARENT_COLOR, 24'hFFFFFF, colour treated as see-through.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; ignored while busy.
- sprite_x  in  10  screen X of sprite top-left; sampled on accepted start.
- sprite_y  in  10  screen Y of sprite top-left; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last texel is processed.
- rom_addr  out  19  read address to the sprite ROM.
- rom_data  in  24  ROM colour; valid the cycle after rom_addr is presented.
- fb_addr  out  19  frame-buffer write address = y*SCREEN_W + x.
- fb_data  out  24  frame-buffer write colour.
- fb_we  out  1  write valid.
- fb_ready  in  1  write accepted when fb_we && fb_ready at a rising edge.
- written_count  out  11  pixels written this blit; cleared on accepted start.

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE; busy=0, done=0, fb_we=0; rom_addr=0, fb_addr=0, fb_data=0; written_count=0; cursor row=col=0.
- States:
  - IDLE: start=1 latches sprite_x/y, clears cursor and written_count, and moves to FETCH.
  - FETCH: drive rom_addr = ROM_BASE + row*SPRITE_W + col; next state CAPTURE.
  - CAPTURE: register rom_data into the pixel register; compute px = sx+col and py = sy+row as 11-bit values.
    - Pixel is skipped if px >= SCREEN_W, or py >= SCREEN_H, or (with the optional feature) colour == TRANSPARENT_COLOR.
    - If not skipped, go to WRITE. If skipped, go to ADVANCE.
  - WRITE: fb_we=1; fb_addr and fb_data stay stable until fb_ready=1. On acceptance, written_count+1 and go to ADVANCE.
  - ADVANCE:
    - col+1. At col == SPRITE_W-1: col=0, row+1.
    - At the last texel (row == SPRITE_H-1 && col == SPRITE_W-1): go to DONE. Otherwise go to FETCH.
  - DONE: done=1 for exactly one cycle, then IDLE; busy=0 in the cycle done is high.
- busy=1 in all states except IDLE and DONE.
- Cycle costs (fb_ready=1): opaque pixel 4 cycles; skipped pixel 3 cycles.
- rom_addr holds its value outside FETCH. Only the FETCH→CAPTURE sampling matters.
- start while busy/DONE: ignored; no relatch.
- fb_ready high while fb_we=0: no effect.
- fb_addr arithmetic: py*SCREEN_W + px computed at 19 bits, no overflow within 640x480.
- Reset mid-blit: immediate abort. fb_we drops asynchronously; no partial resume; next start restarts at texel 0.

Optional Feature:
- Macro SPRITE_BLIT_TRANSPARENCY_EN.
- Defined: texels equal to TRANSPARENT_COLOR are skipped (no write).
- Undefined: every on-screen texel is written regardless of colour. TRANSPARENT_COLOR is unused.

Decomposition:
- Package sprite_pkg: typedef rgb_t (logic [23:0]); constants SCREEN_W and SCREEN_H; blit_state_t enum {IDLE, FETCH, CAPTURE, WRITE, ADVANCE, DONE}.
- One natural sub-module, sprite_blit_cursor: row/col counter with clear, advance, and a last flag.

Test Plan:
- Reset: Reset_n=0 mid-cycle -> busy=0, done=0, fb_we=0, written_count=0 immediately.
- Basic blit: start at (100,50), ROM all 24'h000000, fb_ready=1.
  - Expect 1024 writes; first fb_addr=32100, last fb_addr=51971.
  - Expect one done pulse, written_count=1024.
  - A second start pulsed mid-blit is ignored.
- Transparency: ROM texel 5 = 24'hFFFFFF.
  - Macro defined -> fb_addr 32105 never written, written_count=1023.
  - Macro undefined -> 1024 writes.
- Backpressure: fb_ready=0 for 7 cycles on the first write.
  - fb_we, fb_addr=32100, fb_data stable all 7 cycles.
  - Exactly one write accepted when fb_ready rises.
- Clipping: start at (620,470) -> written_count=200; all fb_addr < 307200; all 1024 ROM addresses 0..1023 still issued in order.
- Reset mid-op: assert Reset_n=0 after 10 writes.
  - fb_we=0 at once.
  - A new start at (0,0) -> first fb_addr=0, rom_addr=0, written_count restarts from 0.
